// File: rtl/key_debouncer_if.sv
// Board-side bundle for key_debouncer: raw active-low KEY pins plus the
// per-key conditioned event outputs.
interface key_debouncer_if #(
  parameter int unsigned NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] KEY;
  logic [NUM_KEYS-1:0] pressed;
  logic [NUM_KEYS-1:0] press_pulse;
  logic [NUM_KEYS-1:0] release_pulse;
  logic [NUM_KEYS-1:0] long_pulse;
  logic [NUM_KEYS-1:0] toggle;

  // master: the pins and the event consumer; slave: the debouncer itself
  modport master (
    output KEY,
    input  pressed, press_pulse, release_pulse, long_pulse, toggle
  );

  modport slave (
    input  KEY,
    output pressed, press_pulse, release_pulse, long_pulse, toggle
  );
endinterface

// File: rtl/key_debouncer.sv
// Per-key push-button conditioner: 2-flop sync, 4-state debounce FSM,
// press/release/long-press pulses and a press-toggled latch.
module key_debouncer #(
  parameter int unsigned NUM_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 50000000
) (
  input  logic         CLOCK_50,
  input  logic         RST_N,
  key_debouncer_if.slave kif
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HW = $clog2(LONG_PRESS_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_PRESS_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_PEND,
    PRESSED,
    RELEASE_PEND
  } state_e;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [1:0]    sync_q;
    logic          ks;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          pressed_q, pressed_d;
    logic          ppulse_q, ppulse_d;
    logic          rpulse_q, rpulse_d;
    logic          lpulse_q, lpulse_d;
    logic          tog_q, tog_d;

    // sync_q[1] is the second stage; pins idle high (released)
    assign ks = ~sync_q[1];

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
      if (!RST_N) begin
        sync_q    <= '1;
        state_q   <= RELEASED;
        cnt_q     <= '0;
        hold_q    <= '0;
        pressed_q <= 1'b0;
        ppulse_q  <= 1'b0;
        rpulse_q  <= 1'b0;
        lpulse_q  <= 1'b0;
        tog_q     <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], kif.KEY[k]};
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        hold_q    <= hold_d;
        pressed_q <= pressed_d;
        ppulse_q  <= ppulse_d;
        rpulse_q  <= rpulse_d;
        lpulse_q  <= lpulse_d;
        tog_q     <= tog_d;
      end
    end

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      ppulse_d  = 1'b0;
      rpulse_d  = 1'b0;
      tog_d     = tog_q;

      case (state_q)
        RELEASED: begin
          if (ks) begin
            state_d = PRESS_PEND;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        PRESS_PEND: begin
          if (!ks) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = PRESSED;
            cnt_d     = '0;
            pressed_d = 1'b1;
            ppulse_d  = 1'b1;
            tog_d     = ~tog_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        PRESSED: begin
          if (!ks) begin
            state_d = RELEASE_PEND;
            cnt_d   = CW'(1);
          end else begin
            cnt_d   = '0;
          end
        end
        RELEASE_PEND: begin
          if (ks) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cnt_q == CNT_LAST) begin
            state_d   = RELEASED;
            cnt_d     = '0;
            pressed_d = 1'b0;
            rpulse_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      endcase

      // Hold count follows the registered level, so RELEASE_PEND bounce keeps it;
      // saturation at HOLD_MAX makes the HOLD_LAST match occur once per press.
      hold_d = hold_q;
      if (!pressed_q) begin
        hold_d = '0;
      end else if (hold_q != HOLD_MAX) begin
        hold_d = hold_q + HW'(1);
      end
      lpulse_d = pressed_q && (hold_q == HOLD_LAST);
    end

    assign kif.pressed[k]       = pressed_q;
    assign kif.press_pulse[k]   = ppulse_q;
    assign kif.release_pulse[k] = rpulse_q;
    assign kif.long_pulse[k]    = lpulse_q;
    assign kif.toggle[k]        = tog_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// Directed bench for key_debouncer with DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=10.
module tb_key_debouncer;
  localparam int unsigned NK = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned LP = 10;

  logic CLOCK_50 = 1'b0;
  logic RST_N;
  int unsigned total = 0;
  int unsigned bad   = 0;

  key_debouncer_if #(.NUM_KEYS(NK)) kif ();

  key_debouncer #(
    .NUM_KEYS         (NK),
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RST_N   (RST_N),
    .kif     (kif)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick(input int unsigned n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] all_o();
    return {kif.pressed, kif.press_pulse, kif.release_pulse, kif.long_pulse, kif.toggle};
  endfunction

  initial begin
    RST_N   = 1'b0;
    kif.KEY = 4'hF;
    #23;
    chk("reset_all", all_o(), 20'h0);
    tick(1);
    RST_N = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      chk("idle_all", all_o(), 20'h0);
    end

    // single press on key 0, release afterwards
    kif.KEY[0] = 1'b0;
    tick(5);
    chk("k0_pend_pressed", kif.pressed, 4'b0000);
    chk("k0_pend_pp", kif.press_pulse, 4'b0000);
    tick(1);
    chk("k0_pressed", kif.pressed, 4'b0001);
    chk("k0_pp", kif.press_pulse, 4'b0001);
    chk("k0_toggle", kif.toggle, 4'b0001);
    chk("k0_rp_quiet", kif.release_pulse, 4'b0000);
    tick(1);
    chk("k0_pp_end", kif.press_pulse, 4'b0000);
    chk("k0_still", kif.pressed, 4'b0001);
    kif.KEY[0] = 1'b1;
    tick(5);
    chk("k0_rel_pend", kif.pressed, 4'b0001);
    chk("k0_rel_pend_rp", kif.release_pulse, 4'b0000);
    tick(1);
    chk("k0_rp", kif.release_pulse, 4'b0001);
    chk("k0_released", kif.pressed, 4'b0000);
    chk("k0_toggle_kept", kif.toggle, 4'b0001);
    tick(1);
    chk("k0_rp_end", kif.release_pulse, 4'b0000);

    // short glitch on key 1 rejected
    kif.KEY[1] = 1'b0;
    tick(3);
    kif.KEY[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      chk("k1_glitch", {kif.pressed[1], kif.press_pulse[1]}, 20'h0);
    end
    // alternating burst, then a clean fall
    for (int i = 0; i < 20; i++) begin
      kif.KEY[1] = (i % 2 == 1);
      tick(1);
      chk("k1_burst", {kif.pressed[1], kif.press_pulse[1]}, 20'h0);
    end
    kif.KEY[1] = 1'b0;
    tick(5);
    chk("k1_fall_pend", kif.press_pulse, 4'b0000);
    tick(1);
    chk("k1_pp", kif.press_pulse, 4'b0010);
    chk("k1_pressed", kif.pressed, 4'b0010);
    chk("k1_toggle", kif.toggle, 4'b0011);
    tick(1);
    chk("k1_pp_end", kif.press_pulse, 4'b0000);
    kif.KEY[1] = 1'b1;
    tick(8);
    chk("k1_released", kif.pressed, 4'b0000);

    // long press on key 2, twice
    kif.KEY[2] = 1'b0;
    tick(6);
    chk("k2_pressed", kif.pressed, 4'b0100);
    chk("k2_toggle", kif.toggle, 4'b0111);
    tick(9);
    chk("k2_lp_early", kif.long_pulse, 4'b0000);
    tick(1);
    chk("k2_lp", kif.long_pulse, 4'b0100);
    tick(1);
    chk("k2_lp_end", kif.long_pulse, 4'b0000);
    tick(13);
    chk("k2_lp_once", kif.long_pulse, 4'b0000);
    chk("k2_held", kif.pressed, 4'b0100);
    kif.KEY[2] = 1'b1;
    tick(5);
    chk("k2_rel_pend", kif.release_pulse, 4'b0000);
    tick(1);
    chk("k2_rp", kif.release_pulse, 4'b0100);
    chk("k2_released", kif.pressed, 4'b0000);
    tick(1);
    kif.KEY[2] = 1'b0;
    tick(6);
    chk("k2_repress", kif.pressed, 4'b0100);
    chk("k2_toggle_back", kif.toggle, 4'b0011);
    tick(9);
    chk("k2_lp2_early", kif.long_pulse, 4'b0000);
    tick(1);
    chk("k2_lp2", kif.long_pulse, 4'b0100);
    tick(1);
    chk("k2_lp2_end", kif.long_pulse, 4'b0000);
    kif.KEY[2] = 1'b1;
    tick(8);
    chk("k2_rel2", kif.pressed, 4'b0000);
    chk("k2_rel2_lp", kif.long_pulse, 4'b0000);

    // keys 0 and 3 together
    kif.KEY = 4'b0110;
    tick(6);
    chk("k03_pp", kif.press_pulse, 4'b1001);
    chk("k03_pressed", kif.pressed, 4'b1001);
    chk("k03_toggle", kif.toggle, 4'b1010);
    tick(1);
    kif.KEY = 4'hF;
    tick(6);
    chk("k03_rp", kif.release_pulse, 4'b1001);
    tick(2);
    chk("k03_released", kif.pressed, 4'b0000);
    kif.KEY[0] = 1'b0;
    tick(6);
    chk("k0_tog_a", kif.toggle, 4'b1011);
    chk("k0_pp_a", kif.press_pulse, 4'b0001);
    tick(1);
    kif.KEY[0] = 1'b1;
    tick(8);
    kif.KEY[0] = 1'b0;
    tick(6);
    chk("k0_tog_b", kif.toggle, 4'b1010);
    chk("k0_pp_b", kif.press_pulse, 4'b0001);
    tick(1);
    kif.KEY[0] = 1'b1;
    tick(8);
    chk("k0_rel_b", kif.pressed, 4'b0000);

    // async reset while key 0 held
    kif.KEY[0] = 1'b0;
    tick(8);
    chk("k0_pre_rst", kif.pressed, 4'b0001);
    chk("k0_pre_rst_tog", kif.toggle, 4'b1011);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_all", all_o(), 20'h0);
    tick(2);
    RST_N = 1'b1;
    tick(5);
    chk("post_rst_pend", kif.press_pulse, 4'b0000);
    chk("post_rst_pend_pr", kif.pressed, 4'b0000);
    tick(1);
    chk("post_rst_pp", kif.press_pulse, 4'b0001);
    chk("post_rst_pressed", kif.pressed, 4'b0001);
    chk("post_rst_toggle", kif.toggle, 4'b0001);
    tick(1);
    chk("post_rst_pp_end", kif.press_pulse, 4'b0000);
    kif.KEY = 4'hF;
    tick(8);
    chk("final_released", kif.pressed, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
